// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide mode-0 SPI master with programmable SCK divider
// One byte per data-register write; CS is purely software controlled.
module spi_master #(
    parameter int               DIV_W     = 8,
    parameter logic [DIV_W-1:0] DIV_RESET = 8'd2
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        we_data,
    input  logic        we_ctrl,
    input  logic        rd_data_stb,
    input  logic [15:0] wd,
    output logic [7:0]  rx_data,
    output logic [3:0]  status,
    output logic        sck,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_bits;
    logic             r_phase;
    logic             r_sck;
    logic             r_mosi;
    logic             r_cs_active;
    logic             r_overrun;
    logic             r_done;

    logic             w_busy;
    logic             w_start;
    logic             w_div_wr;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_half_end;
    logic             w_last;

    assign w_busy     = (r_state == S_XFER);
    assign w_start    = we_data && !w_busy;
    assign w_div_wr   = we_ctrl && !w_busy;
    // A control write in the start cycle must already govern this transfer.
    assign w_div_eff  = w_div_wr ? wd[8+DIV_W-1:8] : r_div;
    assign w_half_end = w_busy && (r_cnt == '0);
    assign w_last     = w_half_end && r_phase && (r_bits == 3'd7);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_XFER;
            S_XFER:  if (w_last)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_shift     <= 8'h00;
            r_rx        <= 8'h00;
            r_div       <= DIV_RESET;
            r_cnt       <= '0;
            r_bits      <= 3'd0;
            r_phase     <= 1'b0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_active <= 1'b0;
            r_overrun   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (we_ctrl) begin
                r_cs_active <= wd[0];
                r_overrun   <= 1'b0;
            end
            if (w_div_wr)           r_div     <= wd[8+DIV_W-1:8];
            if (we_data && w_busy)  r_overrun <= 1'b1;
            if (rd_data_stb)        r_done    <= 1'b0;

            if (w_start) begin
                r_shift <= wd[7:0];
                r_mosi  <= wd[7];
                r_done  <= 1'b0;
                r_cnt   <= w_div_eff;
                r_phase <= 1'b0;
                r_bits  <= 3'd0;
            end else if (w_busy) begin
                if (w_half_end) begin
                    r_cnt <= r_div;
                    if (!r_phase) begin
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[6:0], miso};
                        r_phase <= 1'b1;
                    end else begin
                        r_sck   <= 1'b0;
                        r_phase <= 1'b0;
                        if (r_bits == 3'd7) begin
                            r_done <= 1'b1;
                            r_rx   <= r_shift;
                            r_bits <= 3'd0;
                        end else begin
                            // shift has already moved left, so bit 7 is the next bit out
                            r_mosi <= r_shift[7];
                            r_bits <= r_bits + 3'd1;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign rx_data = r_rx;
    assign status  = {r_cs_active, r_overrun, r_done, w_busy};
    assign sck     = r_sck;
    assign mosi    = r_mosi;
    assign cs_n    = ~r_cs_active;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed and randomized bench for spi_master
module tb_spi_master;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        we_data = 1'b0;
    logic        we_ctrl = 1'b0;
    logic        rd_data_stb = 1'b0;
    logic [15:0] wd = 16'h0000;
    logic [7:0]  rx_data;
    logic [3:0]  status;
    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic        miso;
    logic        loop_mode = 1'b0;
    logic        miso_r = 1'b0;

    int errors = 0;
    int checks = 0;

    assign miso = loop_mode ? mosi : miso_r;

    always #5 clk = ~clk;

    spi_master #(.DIV_W(8), .DIV_RESET(8'd2)) dut (
        .clk(clk), .resetq(resetq), .we_data(we_data), .we_ctrl(we_ctrl),
        .rd_data_stb(rd_data_stb), .wd(wd), .rx_data(rx_data), .status(status),
        .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctrl(input logic [15:0] w);
        wd = w;
        we_ctrl = 1'b1;
        @(negedge clk);
        we_ctrl = 1'b0;
    endtask

    // Slave view of one byte: expected bits, phase lengths and duration come
    // straight from the SPI mode-0 rules, independent of the DUT internals.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] srx, input int d,
                        input bit lp, input int inj_at, input int rd_at,
                        input bit wctl, input logic [7:0] hi);
        int cyc, rises, run_len, bad;
        logic run_val;
        logic [7:0] cap;
        cyc = 0; rises = 0; run_len = 0; bad = 0; run_val = 1'b0; cap = 8'h00;
        loop_mode = lp;
        miso_r = srx[7];
        wd = {hi, tx};
        we_data = 1'b1;
        we_ctrl = wctl;
        @(negedge clk);
        we_data = 1'b0;
        we_ctrl = 1'b0;
        if (wctl) check("cs_with_start", 32'(cs_n), 32'd0);
        while (status[0] === 1'b1 && cyc < 16 * (d + 1) + 20) begin
            cyc++;
            if (sck === run_val) begin
                run_len++;
            end else begin
                if (run_len != d + 1) bad++;
                run_val = sck;
                run_len = 1;
                if (sck === 1'b1) begin
                    cap = {cap[6:0], mosi};
                    rises++;
                    if (rises < 8) miso_r = srx[7 - rises];
                end
            end
            we_data = (cyc == inj_at);
            if (cyc == inj_at) wd = 16'h00FF;
            rd_data_stb = (cyc == rd_at);
            @(negedge clk);
        end
        we_data = 1'b0;
        rd_data_stb = 1'b0;
        if (run_len != d + 1) bad++;
        check("busy_cycles", 32'(cyc), 32'(16 * (d + 1)));
        check("sck_rises", 32'(rises), 32'd8);
        check("mosi_bits", 32'(cap), 32'(tx));
        check("phase_len_errs", 32'(bad), 32'd0);
        check("rx_data", 32'(rx_data), 32'(lp ? tx : srx));
        check("done_set", 32'(status[1]), 32'd1);
        check("busy_clear", 32'(status[0]), 32'd0);
    endtask

    initial begin
        int highs, k, n, dd;
        logic prev;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        resetq = 1'b1;
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sck !== 1'b0) highs++;
        end
        check("idle_no_sck", 32'(highs), 32'd0);

        ctrl(16'h0001);
        check("cs_asserted", 32'(cs_n), 32'd0);
        check("status_cs", 32'(status), 32'h8);
        xfer(8'hA5, 8'h00, 0, 1'b1, -1, -1, 1'b0, 8'h00);

        ctrl(16'h0301);
        xfer(8'h96, 8'h3C, 3, 1'b0, -1, -1, 1'b0, 8'h00);

        ctrl(16'h0001);
        xfer(8'h55, 8'($urandom), 0, 1'b0, 5, -1, 1'b0, 8'h00);
        check("overrun_set", 32'(status[2]), 32'd1);
        ctrl(16'h0001);
        check("overrun_clr", 32'(status[2]), 32'd0);

        rd_data_stb = 1'b1;
        @(negedge clk);
        rd_data_stb = 1'b0;
        check("done_cleared", 32'(status[1]), 32'd0);
        xfer(8'h3A, 8'hC5, 0, 1'b0, -1, 16, 1'b0, 8'h00);
        xfer(8'h81, 8'h7E, 0, 1'b0, -1, -1, 1'b0, 8'h00);
        check("b2b_no_overrun", 32'(status[2]), 32'd0);

        ctrl(16'h0000);
        check("cs_released", 32'(cs_n), 32'd1);
        xfer(8'hC3, 8'h19, 1, 1'b0, -1, -1, 1'b1, 8'h01);

        for (int i = 0; i < 4; i++) begin
            dd = int'($urandom_range(0, 3));
            ctrl({8'(dd), 8'h01});
            b = 8'($urandom);
            xfer(b, 8'($urandom), dd, 1'($urandom_range(0, 1)), -1, -1, 1'b0, 8'h00);
        end

        ctrl(16'h0001);
        wd = 16'h00C3;
        we_data = 1'b1;
        @(negedge clk);
        we_data = 1'b0;
        k = 0; n = 0; prev = 1'b0;
        while (k < 200) begin
            if (sck === 1'b1 && prev === 1'b0) n++;
            if (n == 5) break;
            prev = sck;
            @(negedge clk);
            k++;
        end
        check("fifth_high_seen", 32'(n), 32'd5);
        resetq = 1'b0;
        #1;
        check("mid_rst_sck", 32'(sck), 32'd0);
        check("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check("mid_rst_busy", 32'(status[0]), 32'd0);
        check("mid_rst_rx", 32'(rx_data), 32'd0);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        xfer(8'h6D, 8'hB2, 2, 1'b0, -1, -1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
